// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding valid/ready load/store with LATENCY wait states.
// Optional DMEM_ACCESS_ERR_EN: misaligned or out-of-range addresses return an error response.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic            r_err;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [31:0]     r_rsp_rdata;
    logic            r_rsp_err;

    logic            w_accept;
    logic            w_access;
    logic            w_hs;
    logic            w_req_err;
    logic            w_acc_we;
    logic            w_acc_err;
    logic [AW-1:0]   w_acc_idx;
    logic [31:0]     w_acc_wdata;

`ifdef DMEM_ACCESS_ERR_EN
    assign w_req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
`else
    // Byte-offset and upper address bits are intentionally dropped (wrap modulo depth).
    logic w_unused;
    assign w_unused  = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign w_req_err = 1'b0;
`endif

    // Holding rstn low also blocks acceptance, so no zero-latency write can slip into memory.
    assign w_accept = rstn && (r_state == IDLE) && req_valid;
    assign w_hs     = (r_state == RESP) && rsp_ready;
    assign w_access = (w_accept && (LATENCY == 0)) || ((r_state == WAIT) && (r_cnt == 4'd0));

    // With zero latency the access happens on the accept edge, so it must use the live request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_acc_we    = r_we;
        w_acc_err   = r_err;
        w_acc_idx   = r_idx;
        w_acc_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_acc_we    = req_we;
            w_acc_err   = w_req_err;
            w_acc_idx   = req_addr[AW+1:2];
            w_acc_wdata = req_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_err   <= w_req_err;
                r_idx   <= req_addr[AW+1:2];
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_access) begin
            r_rsp_err   <= w_acc_err;
            r_rsp_rdata <= (w_acc_we || w_acc_err) ? 32'd0 : r_mem[w_acc_idx];
        end else if (w_hs) begin
            r_rsp_err   <= 1'b0;
        end
    end

    // NOTE: the memory array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_access && w_acc_we && !w_acc_err)
            r_mem[w_acc_idx] <= w_acc_wdata;
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 0, 3) sharing clock and reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    // Issues one request with rsp_ready high; lat counts edges from accept until rsp_valid (capped at 50).
    task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_run++; if (req_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready[%0d]: got %b want 1", d, req_ready[d]); end
            n_run++; if (rsp_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid[%0d]: got %b want 0", d, rsp_valid[d]); end
            n_run++; if (rsp_rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata[%0d]: got %h want 0", d, rsp_rdata[d]); end
            n_run++; if (rsp_err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err[%0d]: got %b want 0", d, rsp_err[d]); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL basic_wr_latency: got %0d want 2", lat); end
        n_run++; if (rd !== 32'd0) begin n_fail++; $display("FAIL basic_wr_rdata: got %h want 0", rd); end
        n_run++; if (er !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err: got %b want 0", er); end
        n_run++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after_wr: got ready=%b valid=%b want 1/0", req_ready[0], rsp_valid[0]); end
        txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL basic_rd_latency: got %0d want 2", lat); end
        n_run++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_rdata: got %h want deadbeef", rd); end
        n_run++; if (er !== 1'b0) begin n_fail++; $display("FAIL basic_rd_err: got %b want 0", er); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
        @(posedge clk); #1;
        // Keep a conflicting write request asserted; it must never be accepted before IDLE.
        req_we[0] = 1'b1; req_wdata[0] = 32'hFFFFFFFF;
        lat = 0;
        while (rsp_valid[0] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_run++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, rsp_valid[0]); end
            n_run++; if (rsp_rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_hold_rdata[%0d]: got %h want deadbeef", i, rsp_rdata[0]); end
            n_run++; if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL bp_hold_err[%0d]: got %b want 0", i, rsp_err[0]); end
            n_run++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_hold_req_ready[%0d]: got %b want 0", i, req_ready[0]); end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        n_run++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle: got valid=%b ready=%b want 0/1", rsp_valid[0], req_ready[0]); end
        req_valid[0] = 1'b0;
        txn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_run++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_no_stray_write: got %h want deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; int c0;
        logic [31:0] vals [4] = '{32'h0BADF00D, 32'h12345678, 32'hFFFF0000, 32'h00C0FFEE};
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b1, 32'(i * 4), vals[i], rd, er, lat);
            n_run++; if (lat !== 0) begin n_fail++; $display("FAIL b2b_wr_latency[%0d]: got %0d want 0", i, lat); end
        end
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b0, 32'(i * 4), 32'h0, rd, er, lat);
            n_run++; if (rd !== vals[i]) begin n_fail++; $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, rd, vals[i]); end
        end
        n_run++; if (cyc - c0 !== 16) begin n_fail++; $display("FAIL b2b_total_cycles: got %0d want 16", cyc - c0); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat;
        rsp_ready[2] = 1'b1;
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0; #1;
        n_run++; if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin n_fail++; $display("FAIL rst_wait_outputs: got valid=%b ready=%b want 0/1", rsp_valid[2], req_ready[2]); end
        @(posedge clk); #1; rstn = 1'b1;
        repeat (4) @(posedge clk); #1;
        n_run++; if (rsp_valid[2] !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_resp: got %b want 0", rsp_valid[2]); end
        txn(2, 1'b0, 32'h20, 32'h0, rd, er, lat);
        n_run++; if (lat !== 3) begin n_fail++; $display("FAIL rst_wait_rd_latency: got %0d want 3", lat); end
        n_run++; if (rd === 32'h12345678) begin n_fail++; $display("FAIL rst_wait_discard: got %h want anything but 12345678", rd); end
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] rd; logic er; int lat;
        rsp_ready[2] = 1'b0;
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h24; req_wdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        lat = 0;
        while (rsp_valid[2] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        rstn = 1'b0; #1;
        n_run++; if (rsp_valid[2] !== 1'b0 || rsp_err[2] !== 1'b0) begin n_fail++; $display("FAIL rst_resp_outputs: got valid=%b err=%b want 0/0", rsp_valid[2], rsp_err[2]); end
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;
        txn(2, 1'b0, 32'h24, 32'h0, rd, er, lat);
        n_run++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_resp_committed: got %h want cafef00d", rd); end
    endtask

`ifdef DMEM_ACCESS_ERR_EN
    task automatic test_access_err();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h4, 32'h13572468, rd, er, lat);
        txn(0, 1'b1, 32'h6, 32'hFFFF0000, rd, er, lat);
        n_run++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned_err: got %b want 1", er); end
        n_run++; if (rd !== 32'd0) begin n_fail++; $display("FAIL err_misaligned_rdata: got %h want 0", rd); end
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL err_misaligned_latency: got %0d want 2", lat); end
        txn(0, 1'b0, 32'h4, 32'h0, rd, er, lat);
        n_run++; if (rd !== 32'h13572468 || er !== 1'b0) begin n_fail++; $display("FAIL err_mem_unchanged: got %h/%b want 13572468/0", rd, er); end
        txn(0, 1'b0, 32'h1000, 32'h0, rd, er, lat);
        n_run++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_range_read: got %h/%b want 0/1", rd, er); end
    endtask
`else
    task automatic test_addr_wrap();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h1004, 32'hA5A5A5A5, rd, er, lat);
        n_run++; if (er !== 1'b0) begin n_fail++; $display("FAIL wrap_wr_err: got %b want 0", er); end
        txn(0, 1'b0, 32'h0004, 32'h0, rd, er, lat);
        n_run++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wrap_rd_data: got %h want a5a5a5a5", rd); end
        n_run++; if (er !== 1'b0) begin n_fail++; $display("FAIL wrap_rd_err: got %b want 0", er); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        test_reset_in_resp();
`ifdef DMEM_ACCESS_ERR_EN
        test_access_err();
`else
        test_addr_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the slave end of the processor's load/store port, replacing the zero-wait-state data memory. It accepts one word read or write over a valid/ready request channel and applies a programmable number of wait states. It returns a read word or write acknowledgement over a valid/ready response channel. Only one transaction is outstanding at a time, which lets a stalling core or bus bridge treat it as a blocking memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two ≥ 2.
- LATENCY, 2: wait cycles between request acceptance and response; legal range 0–15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; the word index is req_addr[log2(DEPTH_WORDS)+1:2].
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  read data; 0 for write responses.
- rsp_err  out  1  error response (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&req_ready, the block captures we, addr and wdata into internal registers.
  - Next state is WAIT with wait counter = LATENCY-1 when LATENCY≥1, else RESP directly.
  - Request inputs are ignored outside this accept edge.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle.
  - When the counter reads 0, the block performs the access on that edge and enters RESP.
- Access, performed on the edge entering RESP:
  - A write commits the captured wdata to mem[index].
  - A read registers mem[index] into rsp_rdata.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that handshake the block returns to IDLE.
  - req_ready=0 throughout RESP; a request is never accepted in the handshake cycle.
- Write responses carry rsp_rdata=0.
- Memory contents are not cleared by reset; they are X until written.
- Reset mid-operation (WAIT or RESP):
  - The FSM returns to IDLE immediately.
  - A write still in WAIT is discarded (never committed).
  - A write already in RESP remains committed.
  - rsp_valid and rsp_err drop immediately.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; the wait counter and captured registers are cleared to 0.
- If acceptance happens at edge k, rsp_valid is first high in the cycle after edge k+LATENCY.
  - LATENCY=0: rsp_valid is high in the cycle right after the acceptance edge.
- With rsp_ready held high, the minimum transaction period is LATENCY+2 cycles (accept, LATENCY waits, 1 response cycle).
- Read-after-write to the same address in consecutive transactions returns the new data: the write commits before RESP, so the later read sees it.
- The counter is 4 bits and does not wrap for legal LATENCY values.
- All outputs are registered or decoded from the FSM state only; there are no combinational input-to-output paths.

## Configuration
- Macro: DMEM_ACCESS_ERR_EN.
- Defined:
  - req_addr[1:0]≠0 or req_addr ≥ 4·DEPTH_WORDS produces an error response.
  - On an error response, no memory write occurs, rsp_rdata=0 and rsp_err=1.
  - Error responses keep the same latency as normal accesses.
- Undefined:
  - req_addr[1:0] is ignored.
  - Addresses beyond the array wrap modulo DEPTH_WORDS (upper bits are dropped).
  - rsp_err is tied to 0.

## Test plan
- Basic write/read, LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10 → each rsp_valid is first high 3 cycles after its accept edge; the read returns rsp_rdata=0xDEADBEEF and the write response has rsp_rdata=0.
- Backpressure: rsp_ready held low for 5 cycles during a read → rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0; returns to IDLE one cycle after rsp_ready=1.
- LATENCY=0 back-to-back: 4 writes, then 4 reads of addresses 0x0–0xC with rsp_ready=1 → each transaction takes 2 cycles and the read data matches the written data.
- Reset in WAIT, LATENCY=3: assert rstn=0 one cycle after accepting a write of 0x12345678 to 0x20 → rsp_valid=0 and req_ready=1 immediately; a later read of 0x20 does not return 0x12345678.
- With DMEM_ACCESS_ERR_EN: write to 0x6 → rsp_err=1 and memory is unchanged; read at 4·DEPTH_WORDS → rsp_err=1, rsp_rdata=0.
- Without DMEM_ACCESS_ERR_EN, DEPTH_WORDS=1024: write 0xA5A5A5A5 to 0x1004, read 0x0004 → returns 0xA5A5A5A5 and rsp_err=0.
